// File: rtl/tone_sequencer_voice.sv
// tone_sequencer_voice: square-wave tone voice for the Simon Says sound path.
// Takes one note (frequency in Hz, duration in ms), toggles a square wave from
// a phase accumulator, times the note off a millisecond tick and pulses done.
// Optional feature macro: TONE_GAP_EN adds a silent GAP of GAP_MS ms after
// each note before done is reported.
module tone_sequencer_voice #(
  parameter int FREQ_W = 10,
  parameter int DUR_W  = 12,
  parameter int CPM_W  = 16,
  parameter int ACC_W  = 32,
  parameter int GAP_MS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CPM_W-1:0]  clk_per_ms,
  input  logic              start,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUR_W-1:0]  dur_ms,
  output logic              busy,
  output logic              done,
  output logic              sound
);

  // The remaining-ms counter is shared by the note and the gap, so it is
  // sized for whichever of the two can be longer.
  localparam int GAP_W = $clog2(GAP_MS + 1);
  localparam int REM_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;

`ifdef TONE_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_TONE} state_t;
`endif

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sound_q, sound_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CPM_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;

  logic [ACC_W-1:0]    half;
  logic                tick;
  logic [CPM_W-1:0]    ms_next;

  // Half a period of a 1 Hz tone, in units of clocks*Hz: toggling when the
  // accumulator crosses this value yields a square wave at freq Hz.
  assign half    = (ACC_W'(clk_per_ms) * ACC_W'(1000)) >> 1;
  assign tick    = (ms_cnt_q == (clk_per_ms - CPM_W'(1)));
  assign ms_next = tick ? '0 : (ms_cnt_q + CPM_W'(1));

  // Next-state logic for the note sequencer and tone generator.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sound_d  = sound_q;
    acc_d    = acc_q;
    ms_cnt_d = ms_cnt_q;
    rem_d    = rem_q;
    freq_d   = freq_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && (clk_per_ms != '0)) begin
          freq_d   = freq;
          acc_d    = '0;
          ms_cnt_d = '0;
          sound_d  = 1'b0;
          if (dur_ms == '0) begin
`ifdef TONE_GAP_EN
            if (GAP_MS == 0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_GAP;
              rem_d   = REM_W'(GAP_MS);
              busy_d  = 1'b1;
            end
`else
            // Zero-length note: report completion on the next cycle.
            done_d = 1'b1;
`endif
          end else begin
            state_d = S_TONE;
            rem_d   = REM_W'(dur_ms);
            busy_d  = 1'b1;
          end
        end
      end

      S_TONE: begin
        ms_cnt_d = ms_next;
        if (freq_q != '0) begin
          if (acc_q >= half) begin
            sound_d = ~sound_q;
            acc_d   = acc_q + ACC_W'(freq_q) - half;
          end else begin
            acc_d   = acc_q + ACC_W'(freq_q);
          end
        end else begin
          // Rest note: stay silent and keep the phase frozen.
          sound_d = 1'b0;
        end
        if (tick) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            // Last tick of the note: silence overrides any toggle this cycle.
            sound_d  = 1'b0;
            ms_cnt_d = '0;
`ifdef TONE_GAP_EN
            if (GAP_MS == 0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              rem_d   = REM_W'(GAP_MS);
            end
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef TONE_GAP_EN
      S_GAP: begin
        ms_cnt_d = ms_next;
        sound_d  = 1'b0;
        if (tick) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sound_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any note silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sound_q  <= 1'b0;
      acc_q    <= '0;
      ms_cnt_q <= '0;
      rem_q    <= '0;
      freq_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sound_q  <= sound_d;
      acc_q    <= acc_d;
      ms_cnt_q <= ms_cnt_d;
      rem_q    <= rem_d;
      freq_q   <= freq_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sound = sound_q;

endmodule

// File: doc/tone_sequencer_voice.md
Name: tone_sequencer_voice

Overview:
- Parametrised square-wave tone voice for the Simon Says sound path.
- Accepts one note request at a time: frequency plus duration in milliseconds.
- Generates the tone with a phase accumulator, times the note with a millisecond tick, then reports completion.
- The game FSM issues a note, waits for done, then issues the next one. No external timing is needed.

Parameters:
- FREQ_W, 10, width of frequency request in Hz.
- DUR_W, 12, width of duration request in ms.
- CPM_W, 16, width of clk_per_ms input.
- ACC_W, 32, phase accumulator width; must hold (2^CPM_W-1)*1000 + 2^FREQ_W.
- GAP_MS, 20, silent gap after each note in ms (used only with TONE_GAP_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clk_per_ms  in  CPM_W  clock cycles per millisecond; static during a note.
- start  in  1  one-cycle note request.
- freq  in  FREQ_W  note frequency in Hz; 0 = rest.
- dur_ms  in  DUR_W  note length in ms.
- busy  out  1  high while a note (or gap) is in progress.
- done  out  1  one-cycle pulse on note completion.
- sound  out  1  square-wave output.

Behaviour:
- Reset (rst low, async): state IDLE, busy=0, done=0, sound=0. Accumulator, ms counter and duration counter all 0. Reset mid-note aborts silently.
- half = (clk_per_ms*1000)>>1, computed in ACC_W bits.
- States: IDLE, TONE, GAP (GAP exists only with the macro). busy = (state != IDLE), registered.
- IDLE accepts start when clk_per_ms != 0. On acceptance:
  - latch freq and dur_ms;
  - clear acc, ms_cnt and sound;
  - next state TONE; busy is high on the next cycle.
  - start with clk_per_ms == 0 is ignored.
- start while busy is ignored. Latched values are not disturbed.
- dur_ms == 0 on accept: skip TONE. Go to GAP (macro on) or straight to done (macro off); sound never toggles.
- ms tick: ms_cnt counts 0..clk_per_ms-1 and wraps. tick = (ms_cnt == clk_per_ms-1). ms_cnt restarts at 0 on each state entry.
- TONE, per cycle:
  - if latched freq != 0: when acc >= half (old acc), toggle sound and set acc <= acc + freq - half; otherwise acc <= acc + freq.
  - if latched freq == 0: sound forced 0, acc held.
  - on each tick, decrement the remaining-ms counter.
  - on the tick that makes it 0: sound <= 0, exit TONE.
  - A toggle and exit on the same cycle: exit wins, sound = 0.
- Note length: TONE lasts exactly dur_ms*clk_per_ms cycles.
- Exit to IDLE: done=1 for exactly one cycle and busy=0 on that same cycle. A start on the done cycle is accepted.

Optional Feature:
- Macro TONE_GAP_EN.
- Defined: after TONE, enter GAP for GAP_MS ms with sound=0 and busy=1, then pulse done and go to IDLE.
- Undefined: GAP state and GAP_MS logic are absent. TONE exits directly to IDLE with done.

Test Plan:
- Basic note: clk_per_ms=4, start with freq=500, dur_ms=3, macro off.
  - TONE lasts 12 cycles.
  - sound rises on the 5th TONE cycle, then toggles every 4 cycles.
  - done pulses once; busy falls with done; sound=0 after.
- Rest note: freq=0, dur_ms=2, clk_per_ms=4 -> sound stays 0 for 8 cycles, then done pulse.
- Collisions:
  - start during TONE with different freq -> ignored, waveform unchanged.
  - start on the done cycle -> accepted, busy high next cycle.
- Zero cases:
  - dur_ms=0 -> done one cycle after accept, no toggles.
  - clk_per_ms=0 with start -> busy stays 0.
- Reset mid-note: drop rst during TONE -> sound, busy and done immediately 0. After release, a new start works normally.
- TONE_GAP_EN, GAP_MS=2, clk_per_ms=4, dur_ms=1 -> 4 TONE cycles, then 8 silent cycles with busy=1, then done.
